lfsr_walk: RTL and testbench
============================

# lfsr_walk

Parametrised, stateful LFSR engine with programmable taps, seed load, and multi-step forward/backward walks under a start/busy/done handshake. Generalises the 8-bit single-step next/previous LFSR to any width. Adds a registered state, N-step runs, and detection of irreversible backward steps. It sits beside the sequence-generation logic and is driven by the control FSM that loads taps and seeds and requests walks.

## Interface
- `WIDTH`, 8: LFSR state width, ≥2.
- `CNT_W`, 8: width of the step-count request.
- `RESET_TAPS`, 'h9C: tap mask after reset (WIDTH bits).
- `RESET_SEED`, all ones: state after reset (WIDTH bits).
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `tapEn` in 1: load `tapData` into the tap register.
- `tapData` in WIDTH: tap mask; bit i set means state bit i feeds back.
- `seedEn` in 1: load `seedData` into the state.
- `seedData` in WIDTH: seed value.
- `start` in 1: request a walk; sampled only when idle.
- `np` in 1: walk direction, 1 = next, 0 = previous; latched at start.
- `steps` in CNT_W: number of steps; latched at start.
- `out` out WIDTH: current LFSR state (registered).
- `busy` out 1: walk in progress.
- `done` out 1: one-cycle pulse when a walk completes.
- `lossy` out 1: sticky flag; a previous-step ran with `taps[WIDTH-1]`=0.
- `pos` out WIDTH: step offset from the last seed. Present only with LFSR_PERIOD_EN.
- `atSeed` out 1: `out` equals the last seed. Present only with LFSR_PERIOD_EN.

## Operation
- Next step (Fibonacci, left shift): `s' = {s[W-2:0], ^(s & taps)}`.
- Previous step: `s' = {p, s[W-1:1]}`.
  - If `taps[W-1]`=1: `p = s[0] ^ ^(s[W-1:1] & taps[W-2:0])`. This is the exact inverse.
  - If `taps[W-1]`=0: the MSB was shifted away, so `p = 0` and `lossy` is set.
- FSM states: IDLE and RUN.
  - IDLE→RUN on `start` when `seedEn`=0. Latches `np`, sets remaining = `steps`, clears `lossy`.
  - In RUN, each cycle with remaining > 0: apply one step, decrement remaining.
  - RUN→IDLE when remaining reaches 0. `done` pulses.
  - `steps`=0: one RUN cycle, no state change, then `done`.
- Tap changes:
  - `tapEn` in IDLE loads taps. If `start` is asserted in the same cycle, the walk uses the new taps.
  - `tapEn` in RUN is ignored.
- Seed loads:
  - `seedEn` in IDLE loads the state, clears `lossy`, and drops a simultaneous `start`.
  - `seedEn` in RUN aborts the walk: state = `seedData`, `busy`=0, no `done` pulse.
- `start` in RUN is ignored.
- `rst` overrides everything. Reset values: `out`=RESET_SEED, taps=RESET_TAPS, `busy`=0, `done`=0, `lossy`=0, `pos`=0, FSM=IDLE.
- Remaining count is CNT_W wide and never wraps below 0.

## Timing
- `start` sampled at edge k with `steps`=N:
  - `busy`=1 after edges k .. k+max(N,1)-1.
  - State steps at edges k+1 .. k+N.
  - `done`=1 for exactly the cycle after edge k+max(N,1); `busy` is 0 in that cycle.
- A new `start` is accepted in the same cycle `done` is high.
- `out` and `lossy` update at the same edge as the step that causes them. `lossy` stays set until the next `start` or seed load.
- Tap and seed loads take effect at the sampling edge (1-cycle latency).

## Configuration
- `LFSR_PERIOD_EN` defined:
  - A seed shadow register and `pos` counter are built.
  - Seed load or reset sets `pos`=0 and shadow = seed (RESET_SEED at reset).
  - `pos` changes by +1 per next step and −1 per previous step, modulo 2^WIDTH.
  - `atSeed` = (`out` == shadow), combinational from registers.
- Not defined: no shadow register or counter; `pos` is tied to 0 and `atSeed` to 0.

## Test plan
- Reset, then read outputs → `out`=0xFF, `busy`=0, `done`=0, `lossy`=0.
- taps 0x9C, seed 0xFF, start `np`=1 `steps`=3 → `out` 0xFE, 0xFC, 0xF8 on successive edges. `done` pulses once, 3 cycles after start.
- taps 0x9C, seed 0xFE, start `np`=0 `steps`=1 → `out`=0xFF, `lossy`=0.
- taps 0x5C, seed 0xFE, start `np`=0 `steps`=1 → `out`=0x7F, `lossy`=1. A following `start` clears `lossy`.
- Start `steps`=10, assert `seedEn`=1 with 0xA5 at the third RUN cycle → `out`=0xA5, `busy`=0, no `done`. Also: `steps`=0 → `done` after 1 cycle, `out` unchanged.
- LFSR_PERIOD_EN, taps 0xB8, seed 0x01, `np`=1 `steps`=255 → `atSeed`=1 and `pos`=0xFF at `done`, `atSeed`=0 at every earlier step.

Source files
------------

// File: rtl/lfsr_walk.sv
// lfsr_walk: programmable-tap LFSR walker with start/busy/done handshake; LFSR_PERIOD_EN adds seed shadow, pos and atSeed
module lfsr_walk #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_TAPS = WIDTH'('h9C),
  parameter logic [WIDTH-1:0] RESET_SEED = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tapEn,
  input  logic [WIDTH-1:0] tapData,
  input  logic             seedEn,
  input  logic [WIDTH-1:0] seedData,
  input  logic             start,
  input  logic             np,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             lossy,
  output logic [WIDTH-1:0] pos,
  output logic             atSeed
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d, out_q, out_d, nxt, prv;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic np_q, np_d, done_q, done_d, lossy_q, lossy_d, do_step;
  assign nxt = {out_q[WIDTH-2:0], ^(out_q & taps_q)};
  // without the top tap the shifted-out MSB is unrecoverable, so refill with 0
  assign prv = {taps_q[WIDTH-1] & (out_q[0] ^ ^(out_q[WIDTH-1:1] & taps_q[WIDTH-2:0])), out_q[WIDTH-1:1]};
  assign do_step = state_q == RUN && !seedEn && rem_q != '0;
  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    out_d   = out_q;
    rem_d   = rem_q;
    np_d    = np_q;
    done_d  = 1'b0;
    lossy_d = lossy_q;
    if (seedEn) begin
      state_d = IDLE;
      out_d   = seedData;
      lossy_d = 1'b0;
      taps_d  = (state_q == IDLE && tapEn) ? tapData : taps_q;
    end else if (state_q == IDLE) begin
      taps_d  = tapEn ? tapData : taps_q;
      state_d = start ? RUN : IDLE;
      np_d    = start ? np : np_q;
      rem_d   = start ? steps : rem_q;
      lossy_d = start ? 1'b0 : lossy_q;
    end else begin
      out_d   = do_step ? (np_q ? nxt : prv) : out_q;
      lossy_d = lossy_q | (do_step & !np_q & !taps_q[WIDTH-1]);
      rem_d   = do_step ? rem_q - CNT_W'(1) : rem_q;
      done_d  = rem_q <= CNT_W'(1);
      state_d = done_d ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      taps_q  <= RESET_TAPS;
      out_q   <= RESET_SEED;
      rem_q   <= '0;
      np_q    <= 1'b0;
      done_q  <= 1'b0;
      lossy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      np_q    <= np_d;
      done_q  <= done_d;
      lossy_q <= lossy_d;
    end
  end
  assign out   = out_q;
  assign busy  = state_q == RUN;
  assign done  = done_q;
  assign lossy = lossy_q;
`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] pos_q, pos_d, shadow_q, shadow_d;
  always_comb begin
    shadow_d = seedEn ? seedData : shadow_q;
    pos_d    = seedEn ? '0 : do_step ? (np_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1)) : pos_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= '0;
      shadow_q <= RESET_SEED;
    end else begin
      pos_q    <= pos_d;
      shadow_q <= shadow_d;
    end
  end
  assign pos    = pos_q;
  assign atSeed = out_q == shadow_q;
`else
  assign pos    = '0;
  assign atSeed = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_walk.sv
// tb_lfsr_walk: directed checks of lfsr_walk walks, seeds, taps and handshake timing
module tb_lfsr_walk;
  logic clk = 1'b0, rst = 1'b1, tapEn = 1'b0, seedEn = 1'b0, start = 1'b0, np = 1'b0;
  logic [7:0] tapData = '0, seedData = '0, steps = '0;
  logic [7:0] out, pos;
  logic busy, done, lossy, atSeed;
  int total = 0, bad = 0;
  lfsr_walk dut (
    .clk(clk), .rst(rst), .tapEn(tapEn), .tapData(tapData), .seedEn(seedEn),
    .seedData(seedData), .start(start), .np(np), .steps(steps), .out(out),
    .busy(busy), .done(done), .lossy(lossy), .pos(pos), .atSeed(atSeed)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load(input logic [7:0] t, input logic [7:0] s);
    tapEn = 1'b1; tapData = t; seedEn = 1'b1; seedData = s;
    tick();
    tapEn = 1'b0; seedEn = 1'b0;
  endtask
  task automatic go(input logic dir, input logic [7:0] n);
    start = 1'b1; np = dir; steps = n;
    tick();
    start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({out, busy, done, lossy} !== {8'hFF, 3'b000}) begin
      bad++; $display("FAIL reset out/busy/done/lossy got %h %b%b%b want ff 000", out, busy, done, lossy);
    end
    total++;
`ifdef LFSR_PERIOD_EN
    if ({pos, atSeed} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL reset pos/atSeed got %h %b want 00 1", pos, atSeed);
    end
`else
    if ({pos, atSeed} !== 9'h0) begin
      bad++; $display("FAIL reset pos/atSeed got %h %b want 00 0", pos, atSeed);
    end
`endif
  endtask
  task automatic test_next_walk();
    logic [7:0] eo [5] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF8};
    logic [1:0] ebd [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    load(8'h9C, 8'hFF);
    go(1'b1, 8'd3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out, busy, done} !== {eo[i], ebd[i]}) begin
        bad++; $display("FAIL next_walk[%0d] out/busy/done got %h %b%b want %h %b", i, out, busy, done, eo[i], ebd[i]);
      end
      tick();
    end
  endtask
  task automatic test_prev_exact();
    load(8'h9C, 8'hFE);
    go(1'b0, 8'd1);
    total++;
    if ({out, busy, done} !== {8'hFE, 2'b10}) begin
      bad++; $display("FAIL prev_exact_k out/busy/done got %h %b%b want fe 10", out, busy, done);
    end
    tick();
    total++;
    if ({out, busy, done, lossy} !== {8'hFF, 3'b010}) begin
      bad++; $display("FAIL prev_exact out/busy/done/lossy got %h %b%b%b want ff 010", out, busy, done, lossy);
    end
  endtask
  task automatic test_prev_lossy();
    load(8'h5C, 8'hFE);
    go(1'b0, 8'd1);
    tick();
    total++;
    if ({out, done, lossy} !== {8'h7F, 2'b11}) begin
      bad++; $display("FAIL prev_lossy out/done/lossy got %h %b%b want 7f 11", out, done, lossy);
    end
    tick();
    total++;
    if (lossy !== 1'b1) begin
      bad++; $display("FAIL lossy_sticky got %b want 1", lossy);
    end
    go(1'b1, 8'd0);
    total++;
    if ({out, busy, done, lossy} !== {8'h7F, 3'b100}) begin
      bad++; $display("FAIL zero_steps_k out/busy/done/lossy got %h %b%b%b want 7f 100", out, busy, done, lossy);
    end
    tick();
    total++;
    if ({out, busy, done, lossy} !== {8'h7F, 3'b010}) begin
      bad++; $display("FAIL zero_steps_done out/busy/done/lossy got %h %b%b%b want 7f 010", out, busy, done, lossy);
    end
  endtask
  task automatic test_tap_with_start();
    load(8'h9C, 8'hFE);
    tapEn = 1'b1; tapData = 8'h5C;
    go(1'b0, 8'd1);
    tapEn = 1'b0;
    tick();
    total++;
    if ({out, done, lossy} !== {8'h7F, 2'b11}) begin
      bad++; $display("FAIL tap_with_start out/done/lossy got %h %b%b want 7f 11", out, done, lossy);
    end
  endtask
  task automatic test_abort();
    int dones = 0;
    load(8'h9C, 8'hFF);
    go(1'b1, 8'd10);
    tick(); tick();
    total++;
    if ({out, busy} !== {8'hFC, 1'b1}) begin
      bad++; $display("FAIL abort_pre out/busy got %h %b want fc 1", out, busy);
    end
    seedEn = 1'b1; seedData = 8'hA5;
    tick();
    seedEn = 1'b0;
    total++;
    if ({out, busy, done} !== {8'hA5, 2'b00}) begin
      bad++; $display("FAIL abort out/busy/done got %h %b%b want a5 00", out, busy, done);
    end
    for (int i = 0; i < 12; i++) begin
      dones += int'(done);
      tick();
    end
    total++;
    if ({out, dones} !== {8'hA5, 32'd0}) begin
      bad++; $display("FAIL abort_quiet out/dones got %h %0d want a5 0", out, dones);
    end
  endtask
  task automatic test_back_to_back();
    load(8'h9C, 8'hFF);
    go(1'b1, 8'd1);
    tapEn = 1'b1; tapData = 8'h00;
    tick();
    tapEn = 1'b0;
    total++;
    if ({out, busy, done} !== {8'hFE, 2'b01}) begin
      bad++; $display("FAIL b2b_first out/busy/done got %h %b%b want fe 01", out, busy, done);
    end
    go(1'b0, 8'd1);
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++; $display("FAIL b2b_accept busy/done got %b%b want 10", busy, done);
    end
    tick();
    total++;
    if ({out, done, lossy} !== {8'hFF, 2'b10}) begin
      bad++; $display("FAIL b2b_second out/done/lossy got %h %b%b want ff 10", out, done, lossy);
    end
  endtask
`ifdef LFSR_PERIOD_EN
  task automatic test_period();
    logic [7:0] m = 8'h01;
    load(8'hB8, 8'h01);
    go(1'b1, 8'd255);
    for (int i = 1; i <= 255; i++) begin
      tick();
      m = {m[6:0], ^(m & 8'hB8)};
      total++;
      if (i < 255 && {out, pos, atSeed, done} !== {m, 8'(i), 2'b00}) begin
        bad++; $display("FAIL period[%0d] out/pos/atSeed/done got %h %h %b%b want %h %h 00", i, out, pos, atSeed, done, m, 8'(i));
      end else if (i == 255 && {out, pos, atSeed, done} !== {8'h01, 8'hFF, 2'b11}) begin
        bad++; $display("FAIL period_end out/pos/atSeed/done got %h %h %b%b want 01 ff 11", out, pos, atSeed, done);
      end
    end
    go(1'b0, 8'd2);
    tick(); tick();
    total++;
    if (pos !== 8'hFD) begin
      bad++; $display("FAIL pos_back got %h want fd", pos);
    end
  endtask
`endif
  initial begin
    @(negedge clk);
    test_reset();
    test_next_walk();
    test_prev_exact();
    test_prev_lossy();
    test_tap_with_start();
    test_abort();
    test_back_to_back();
`ifdef LFSR_PERIOD_EN
    test_period();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
